mem_stage_access: RTL and testbench

//  MEM-stage consumer of the EX/MEM pipeline register: takes RegWriteM/MemtoRegM/MemWriteM/ALUOutM/

---
 rtl/mem_stage_access_pkg.sv | 28 ++
 rtl/mem_stage_access_mem_wb_reg.sv | 41 ++++
 rtl/mem_stage_access.sv | 165 ++++++++++++++++
 tb/tb_mem_stage_access.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_access_pkg.sv
// mem_stage_access_pkg: types and constants shared by the MEM stage, its
// MEM/WB register and the writeback mux downstream.
package mem_stage_access_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_REG_AW = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memState_t;

  // MEM/WB bundle as seen by the writeback mux.
  typedef struct packed {
    logic                  regWrite;
    logic                  memtoReg;
    logic [MEM_DATA_W-1:0] readData;
    logic [MEM_DATA_W-1:0] aluOut;
    logic [MEM_REG_AW-1:0] writeReg;
  } memWb_t;

  // A load that also claims to write memory is a malformed decode; it is
  // handled as a store, so only a pure MemtoReg counts as a load.
  function automatic logic isLoadOp(input logic memtoReg, input logic memWrite);
    return memtoReg & ~memWrite;
  endfunction

endpackage

// File: rtl/mem_stage_access_mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register. Loads every cycle; bubble forces an
// all-zero (no-op) entry so a stalled or abandoned access never writes back.
module mem_wb_reg
  import mem_stage_access_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int REG_AW = MEM_REG_AW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bubble,
  input  logic              regWriteIn,
  input  logic              memtoRegIn,
  input  logic [DATA_W-1:0] readDataIn,
  input  logic [DATA_W-1:0] aluOutIn,
  input  logic [REG_AW-1:0] writeRegIn,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [REG_AW-1:0] WriteRegW
);

  // Register stage: clear on reset or bubble, otherwise capture the MEM result.
  always_ff @(posedge clock) begin
    if (reset || bubble) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
    end else begin
      RegWriteW <= regWriteIn;
      MemtoRegW <= memtoRegIn;
      ReadDataW <= readDataIn;
      ALUOutW   <= aluOutIn;
      WriteRegW <= writeRegIn;
    end
  end

endmodule

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM-stage data-memory access over a req/ready handshake,
// front-of-pipe stall while the access is pending, and the MEM/WB register.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject word-misaligned
// accesses (no request, bubble, registered misalign_err pulse).
//
// state | meaning
// IDLE  | no access outstanding; a new access is requested this cycle
// WAIT  | access issued, memory not ready yet; EX/MEM held by StallM
module mem_stage_access
  import mem_stage_access_pkg::*;
#(
  parameter int DATA_W      = MEM_DATA_W,
  parameter int REG_AW      = MEM_REG_AW,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_AW-1:0] WriteRegM,
  output logic              StallM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [REG_AW-1:0] WriteRegW,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              misalign_err,
`endif
  output logic              dmem_timeout
);

  // Counter wide enough to hold TIMEOUT_CYC itself.
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  memState_t          state;
  memState_t          stateNext;
  logic [CNT_W-1:0]   waitCnt;
  logic [CNT_W-1:0]   waitCntNext;
  logic               timeoutNext;
  logic               access;
  logic               isLoad;
  logic               misaligned;
  logic               abandon;
  logic               bubble;
  logic               wbRegWrite;
  logic               wbMemtoReg;
  logic [DATA_W-1:0]  wbReadData;

  assign access = MemtoRegM | MemWriteM;
  assign isLoad = isLoadOp(MemtoRegM, MemWriteM);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = access & (ALUOutM[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign dmem_addr  = ALUOutM;
  assign dmem_wdata = WriteDataM;
  assign dmem_we    = dmem_req & MemWriteM;
  assign StallM     = dmem_req & ~dmem_ready & ~abandon;

  // Stores never write back, even if decode asserted RegWriteM.
  assign wbRegWrite = RegWriteM & ~MemWriteM;
  assign wbMemtoReg = isLoad;
  assign wbReadData = isLoad ? dmem_rdata : '0;

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      waitCnt      <= '0;
      dmem_timeout <= 1'b0;
    end else begin
      state        <= stateNext;
      waitCnt      <= waitCntNext;
      dmem_timeout <= timeoutNext;
    end
  end

  // Next state, memory request and bubble decision.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    timeoutNext = dmem_timeout;
    dmem_req    = 1'b0;
    abandon     = 1'b0;
    bubble      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            bubble = 1'b1;
          end else begin
            dmem_req = 1'b1;
            if (!dmem_ready) begin
              stateNext   = WAIT;
              waitCntNext = CNT_W'(1);
              bubble      = 1'b1;
            end
          end
        end
      end
      WAIT: begin
        // Request stays up through the abandon cycle; the memory sees it drop after.
        dmem_req = 1'b1;
        if (dmem_ready) begin
          stateNext   = IDLE;
          waitCntNext = '0;
        end else if (waitCnt == CNT_W'(TIMEOUT_CYC)) begin
          abandon     = 1'b1;
          bubble      = 1'b1;
          timeoutNext = 1'b1;
          stateNext   = IDLE;
          waitCntNext = '0;
        end else begin
          bubble      = 1'b1;
          waitCntNext = waitCnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext   = IDLE;
        waitCntNext = '0;
      end
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  // One-cycle error flag, aligned with the bubble it produces in MEM/WB.
  always_ff @(posedge clock) begin
    if (reset) misalign_err <= 1'b0;
    else       misalign_err <= (state == IDLE) & misaligned;
  end
`endif

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_mem_wb_reg (
    .clock      (clock),
    .reset      (reset),
    .bubble     (bubble),
    .regWriteIn (wbRegWrite),
    .memtoRegIn (wbMemtoReg),
    .readDataIn (wbReadData),
    .aluOutIn   (ALUOutM),
    .writeRegIn (WriteRegM),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .WriteRegW  (WriteRegW)
  );

endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: directed scenarios plus randomized traffic checked
// against a transaction-level model of the MEM stage.
module tb_mem_stage_access;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          RegWriteM = 1'b0, MemtoRegM = 1'b0, MemWriteM = 1'b0;
  logic [DW-1:0] ALUOutM = '0, WriteDataM = '0;
  logic [RW-1:0] WriteRegM = '0;
  logic          StallM, dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic          dmem_ready = 1'b0;
  logic [DW-1:0] dmem_rdata = '0;
  logic          RegWriteW, MemtoRegW;
  logic [DW-1:0] ReadDataW, ALUOutW;
  logic [RW-1:0] WriteRegW;
  logic          dmem_timeout;
`ifdef MEM_ALIGN_CHECK_EN
  logic          misalign_err;
`endif

  mem_stage_access #(.DATA_W(DW), .REG_AW(RW), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .dmem_timeout(dmem_timeout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: expected MEM/WB contents, sticky timeout, and how many cycles the
  // current access has already stalled the pipeline.
  logic          eRegWrite, eMemtoReg, eTimeout, eMis;
  logic [DW-1:0] eReadData, eAluOut;
  logic [RW-1:0] eWriteReg;
  int            stalledSoFar = 0;
  bit            lastStall = 1'b0;

  // Last observed combinational outputs, for the directed scenarios.
  bit obsReq, obsWe, obsStall;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check the handshake against the model, then
  // check the MEM/WB register after the edge.
  task automatic step(input bit rst, input bit rw, input bit mtr, input bit mw,
                      input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                      input logic [RW-1:0] wr, input bit rdy, input logic [DW-1:0] rd);
    bit isAcc, isSt, isLd, mis, req, ab, stl, done;
    @(negedge clock);
    reset = rst; RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw;
    ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
    dmem_ready = rdy; dmem_rdata = rd;
    #1;
    isAcc = mtr | mw;
    isSt  = mw;
    isLd  = mtr & ~mw;
    mis   = ALIGN && isAcc && (alu[1:0] != 2'b00);
    req   = isAcc && !mis;
    ab    = req && !rdy && (stalledSoFar == TO);
    stl   = req && !rdy && !ab;
    done  = !isAcc || (req && rdy);
    obsReq = dmem_req; obsWe = dmem_req & dmem_we; obsStall = StallM;
    if (!rst) begin
      chk("dmem_req", {31'b0, dmem_req}, {31'b0, req});
      chk("StallM", {31'b0, StallM}, {31'b0, stl});
      chk("dmem_addr", dmem_addr, alu);
      chk("dmem_wdata", dmem_wdata, wd);
      if (req) chk("dmem_we", {31'b0, dmem_we}, {31'b0, isSt});
    end
    if (rst) begin
      {eRegWrite, eMemtoReg, eTimeout, eMis} = '0;
      eReadData = '0; eAluOut = '0; eWriteReg = '0;
      stalledSoFar = 0; lastStall = 1'b0;
    end else begin
      if (done) begin
        eRegWrite = rw && !isSt;
        eMemtoReg = isLd;
        eReadData = isLd ? rd : '0;
        eAluOut   = alu;
        eWriteReg = wr;
      end else begin
        {eRegWrite, eMemtoReg} = '0;
        eReadData = '0; eAluOut = '0; eWriteReg = '0;
      end
      if (ab) eTimeout = 1'b1;
      eMis = mis;
      stalledSoFar = stl ? stalledSoFar + 1 : 0;
      lastStall = stl;
    end
    @(posedge clock);
    #1;
    chk("RegWriteW", {31'b0, RegWriteW}, {31'b0, eRegWrite});
    chk("MemtoRegW", {31'b0, MemtoRegW}, {31'b0, eMemtoReg});
    chk("ReadDataW", ReadDataW, eReadData);
    chk("ALUOutW", ALUOutW, eAluOut);
    chk("WriteRegW", {27'b0, WriteRegW}, {27'b0, eWriteReg});
    chk("dmem_timeout", {31'b0, dmem_timeout}, {31'b0, eTimeout});
`ifdef MEM_ALIGN_CHECK_EN
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, eMis});
`endif
  endtask

  initial begin
    int nWe, nStall, nReq;
    bit rw, mtr, mw, rdy, rst;
    logic [DW-1:0] alu, wd;
    logic [RW-1:0] wr;
    int kind;

    // Reset state
    step(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    step(1, 1, 1, 0, 32'h40, 32'h0, 5'd9, 0, 32'h0);
    chk("reset RegWriteW", {31'b0, RegWriteW}, 32'd0);
    chk("reset ALUOutW", ALUOutW, 32'd0);
    chk("reset timeout", {31'b0, dmem_timeout}, 32'd0);

    // Plain ALU op: one-cycle pass-through, no stall
    step(0, 1, 0, 0, 32'h10, 32'h0, 5'd3, 0, 32'h0);
    chk("alu ALUOutW", ALUOutW, 32'h10);
    chk("alu WriteRegW", {27'b0, WriteRegW}, 32'd3);
    chk("alu RegWriteW", {31'b0, RegWriteW}, 32'd1);
    chk("alu stall", {31'b0, obsStall}, 32'd0);

    // Zero-wait load
    step(0, 1, 1, 0, 32'h40, 32'h0, 5'd7, 1, 32'hDEADBEEF);
    chk("load ReadDataW", ReadDataW, 32'hDEADBEEF);
    chk("load MemtoRegW", {31'b0, MemtoRegW}, 32'd1);
    chk("load stall", {31'b0, obsStall}, 32'd0);

    // Store with ready on the fourth request cycle; RegWriteM is malformed-high
    nWe = 0; nStall = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 1, 32'h44, 32'h1234, 5'd4, (i == 3), 32'h55);
      nWe += obsWe; nStall += obsStall;
      chk("store RegWriteW", {31'b0, RegWriteW}, 32'd0);
    end
    chk("store we cycles", nWe, 32'd4);
    chk("store stall cycles", nStall, 32'd3);

    // Memory never answers: abandoned in the 4th WAIT cycle
    nStall = 0; nReq = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 0, 32'h80, 32'h0, 5'd5, 0, 32'h0);
      nStall += obsStall; nReq += obsReq;
    end
    chk("timeout stall cycles", nStall, 32'd4);
    chk("timeout req cycles", nReq, 32'd5);
    chk("timeout flag", {31'b0, dmem_timeout}, 32'd1);
    step(0, 1, 0, 0, 32'h20, 32'h0, 5'd6, 0, 32'h0);
    chk("timeout sticky", {31'b0, dmem_timeout}, 32'd1);
    chk("resume ALUOutW", ALUOutW, 32'h20);

    // Reset while waiting, then a normal load
    step(0, 1, 1, 0, 32'h90, 32'h0, 5'd8, 0, 32'h0);
    step(0, 1, 1, 0, 32'h90, 32'h0, 5'd8, 0, 32'h0);
    step(1, 1, 1, 0, 32'h90, 32'h0, 5'd8, 0, 32'h0);
    chk("rst-wait timeout", {31'b0, dmem_timeout}, 32'd0);
    chk("rst-wait WriteRegW", {27'b0, WriteRegW}, 32'd0);
    step(0, 1, 1, 0, 32'h94, 32'h0, 5'd9, 1, 32'hCAFE0001);
    chk("post-rst ReadDataW", ReadDataW, 32'hCAFE0001);
    chk("post-rst stall", {31'b0, obsStall}, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    step(0, 1, 1, 0, 32'h42, 32'h0, 5'd2, 1, 32'h77);
    chk("misalign req", {31'b0, obsReq}, 32'd0);
    chk("misalign err", {31'b0, misalign_err}, 32'd1);
    chk("misalign RegWriteW", {31'b0, RegWriteW}, 32'd0);
`endif

    // Randomized traffic; inputs are held while the model says EX/MEM is stalled
    rw = 0; mtr = 0; mw = 0; alu = '0; wd = '0; wr = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!lastStall) begin
        kind = $urandom_range(0, 3);
        rw   = $urandom_range(0, 1);
        mtr  = (kind == 1) || (kind == 3);
        mw   = (kind == 2) || (kind == 3);
        alu  = $urandom;
        if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
        wd   = $urandom;
        wr   = RW'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 3) == 0);
      step(rst, rw, mtr, mw, alu, wd, wr, rdy, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
